// File: rtl/scan_capture_ctrl.sv
// Freezes a scan chain, shifts it out SCAN_WIDTH bits per cycle from the tail, and packs the
// slices into WORD_WIDTH-bit words on a valid/ready stream.
module scan_capture_ctrl #(
  parameter int SCAN_WIDTH   = 1,
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_CYCLES = 64,
  parameter bit RECIRC       = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_scan_any,
  output logic                  o_scan_mode,
  output logic [SCAN_WIDTH-1:0] o_chain_head,
  input  logic [SCAN_WIDTH-1:0] i_chain_tail,
  output logic [WORD_WIDTH-1:0] o_word_data,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_word_last
);

  localparam int P     = WORD_WIDTH / SCAN_WIDTH;
  localparam int POS_W = (P > 1) ? $clog2(P) : 1;
  localparam int CNT_W = $clog2(CHAIN_CYCLES + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(P - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StStall, StDrain} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [POS_W-1:0]      r_pos;
  logic [WORD_WIDTH-1:0] r_acc;
  logic [WORD_WIDTH-1:0] r_word_data;
  logic                  r_word_valid;
  logic                  r_word_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_scan_any;
  logic                  r_scan_mode;

  logic                  w_xfer;
  logic                  w_cnt_last;
  logic                  w_word_done;
  logic                  w_next_completes;
  logic                  w_out_full_after;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [POS_W-1:0]      w_pos_nxt;
  logic [WORD_WIDTH-1:0] w_acc_nxt;

  always_comb begin
    w_xfer           = r_word_valid && i_word_ready;
    w_cnt_last       = (r_cnt == CNT_MAX);
    w_word_done      = (r_pos == POS_MAX) || w_cnt_last;
    w_acc_nxt        = r_acc | (WORD_WIDTH'(i_chain_tail) << (32'(r_pos) * SCAN_WIDTH));
    w_cnt_nxt        = r_cnt + CNT_W'(1);
    w_pos_nxt        = (r_pos == POS_MAX) ? '0 : r_pos + POS_W'(1);
    w_next_completes = (w_pos_nxt == POS_MAX) || (w_cnt_nxt == CNT_MAX);
    // Output register occupancy after this edge, assuming a SHIFT cycle.
    w_out_full_after = w_word_done || (r_word_valid && !i_word_ready);
  end

  always_ff @(posedge i_clk) begin
    r_done <= 1'b0;
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_pos        <= '0;
      r_acc        <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_scan_any   <= 1'b0;
      r_scan_mode  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_word_valid <= 1'b0;
        r_word_last  <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state     <= StShift;
            r_scan_any  <= 1'b1;
            r_scan_mode <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_pos       <= '0;
            r_acc       <= '0;
          end
        end
        StShift: begin
          r_cnt <= w_cnt_last ? '0 : w_cnt_nxt;
          r_pos <= w_pos_nxt;
          if (w_word_done) begin
            r_word_data  <= w_acc_nxt;
            r_word_valid <= 1'b1;
            r_word_last  <= w_cnt_last;
            r_acc        <= '0;
          end else begin
            r_acc <= w_acc_nxt;
          end
          if (w_cnt_last) begin
            r_state     <= StDrain;
            r_scan_any  <= 1'b0;
            r_scan_mode <= 1'b0;
          end else if (w_next_completes && w_out_full_after) begin
            // Hold the chain so a completing slice never overwrites an unaccepted word.
            r_state     <= StStall;
            r_scan_mode <= 1'b0;
          end
        end
        StStall: begin
          if (!r_word_valid || i_word_ready) begin
            r_state     <= StShift;
            r_scan_mode <= 1'b1;
          end
        end
        StDrain: begin
          if (w_xfer) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_scan_any   = r_scan_any;
  assign o_scan_mode  = r_scan_mode;
  assign o_word_data  = r_word_data;
  assign o_word_valid = r_word_valid;
  assign o_word_last  = r_word_last;
  assign o_chain_head = (RECIRC && r_scan_mode) ? i_chain_tail : '0;

endmodule

// File: tb/tb_scan_capture_ctrl.sv
// Bench for scan_capture_ctrl: cycle tables, corner sequences and randomized unloads checked
// against a chain model and a word-packing scoreboard.
module tb_scan_capture_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: 4-bit slices, 16-bit words, 10 shift cycles, no recirculation.
  logic        a_start, a_ready, a_busy, a_done, a_any, a_mode, a_valid, a_last;
  logic [3:0]  a_head, a_tail;
  logic [15:0] a_data;
  logic [3:0]  a_din   [10];
  logic [3:0]  a_chain [10];

  scan_capture_ctrl #(.SCAN_WIDTH(4), .WORD_WIDTH(16), .CHAIN_CYCLES(10), .RECIRC(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
    .o_scan_any(a_any), .o_scan_mode(a_mode), .o_chain_head(a_head), .i_chain_tail(a_tail),
    .o_word_data(a_data), .o_word_valid(a_valid), .i_word_ready(a_ready), .o_word_last(a_last)
  );

  always @(posedge clk) begin
    if (!a_any) begin
      for (int i = 0; i < 10; i++) a_chain[i] <= a_din[i];
    end else if (a_mode) begin
      for (int i = 0; i < 9; i++) a_chain[i] <= a_chain[i+1];
      a_chain[9] <= a_head;
    end
  end
  assign a_tail = a_chain[0];

  // Instance B: one 8-bit element plus its scan stage, recirculating.
  logic       b_start, b_busy, b_done, b_any, b_mode, b_valid, b_last, b_head, b_tail;
  logic [7:0] b_data, b_din;
  logic [8:0] b_chain;

  scan_capture_ctrl #(.SCAN_WIDTH(1), .WORD_WIDTH(8), .CHAIN_CYCLES(9), .RECIRC(1'b1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .o_scan_any(b_any), .o_scan_mode(b_mode), .o_chain_head(b_head), .i_chain_tail(b_tail),
    .o_word_data(b_data), .o_word_valid(b_valid), .i_word_ready(1'b1), .o_word_last(b_last)
  );

  always @(posedge clk) begin
    if (rst) b_chain <= 9'h001;
    else if (!b_any) b_chain[8:1] <= b_din;
    else if (b_mode) b_chain <= {b_head, b_chain[8:1]};
  end
  assign b_tail = b_chain[0];

  // Instance C: single-cycle chain, one slice per word.
  logic       c_start, c_ready, c_busy, c_done, c_any, c_mode, c_valid, c_last;
  logic [7:0] c_head, c_tail, c_data;

  scan_capture_ctrl #(.SCAN_WIDTH(8), .WORD_WIDTH(8), .CHAIN_CYCLES(1), .RECIRC(1'b0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(c_start), .o_busy(c_busy), .o_done(c_done),
    .o_scan_any(c_any), .o_scan_mode(c_mode), .o_chain_head(c_head), .i_chain_tail(c_tail),
    .o_word_data(c_data), .o_word_valid(c_valid), .i_word_ready(c_ready), .o_word_last(c_last)
  );

  typedef struct {
    logic        start, ready;
    logic        any, mode, busy, valid, last, done;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_vectors();
    vec_t v;
    // Ready held high: no stalls, words in cycles 5, 9, 11, DONE in 12.
    for (int c = 0; c < 14; c++) begin
      v.start = (c == 0);
      v.ready = 1'b1;
      v.any   = (c >= 1 && c <= 10);
      v.mode  = (c >= 1 && c <= 10);
      v.busy  = (c >= 1 && c <= 11);
      v.valid = (c == 5 || c == 9 || c == 11);
      v.data  = (c == 5) ? 16'h3210 : (c == 9) ? 16'h7654 : 16'h0098;
      v.last  = (c == 11);
      v.done  = (c == 12);
      vecs.push_back(v);
    end
    // Ready low in cycles 5-14: the slice completing word 1 waits in STALL.
    for (int c = 0; c < 22; c++) begin
      v.start = (c == 0);
      v.ready = !(c >= 5 && c <= 14);
      v.any   = (c >= 1 && c <= 18);
      v.mode  = (c >= 1 && c <= 7) || (c >= 16 && c <= 18);
      v.busy  = (c >= 1 && c <= 19);
      v.valid = (c >= 5 && c <= 15) || c == 17 || c == 19;
      v.data  = (c <= 15) ? 16'h3210 : (c == 17) ? 16'h7654 : 16'h0098;
      v.last  = (c == 19);
      v.done  = (c == 20);
      vecs.push_back(v);
    end
  endfunction

  task automatic apply_vecs();
    foreach (vecs[i]) begin
      tick();
      check($sformatf("vec%0d_ctrl", i), 64'({a_any, a_mode, a_busy, a_valid, a_last, a_done}),
            64'({vecs[i].any, vecs[i].mode, vecs[i].busy, vecs[i].valid, vecs[i].last,
                 vecs[i].done}));
      if (vecs[i].valid) check($sformatf("vec%0d_data", i), 64'(a_data), 64'(vecs[i].data));
      a_start = vecs[i].start;
      a_ready = vecs[i].ready;
    end
  endtask

  // One full unload on instance A, starting in the current (idle) cycle.
  task automatic run_unload(input int unsigned ready_pct, input bit poke);
    logic [15:0] exp_q[$];
    logic [15:0] w;
    logic [15:0] hold_data = '0;
    logic        hold_last = 1'b0;
    bit          hold = 1'b0;
    bit          head_nz = 1'b0;
    int          words = 0;
    int          shifts = 0;
    int          dones = 0;
    for (int wi = 0; wi < 3; wi++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (wi * 4 + j < 10) w = w | (16'(a_din[wi*4+j]) << (4 * j));
      exp_q.push_back(w);
    end
    a_start = 1'b1;
    a_ready = ($urandom_range(99) < ready_pct);
    for (int cyc = 1; cyc < 300 && dones == 0; cyc++) begin
      tick();
      a_start = poke && (cyc == 3 || cyc == 6);
      if (hold) begin
        check("hold_valid", 64'(a_valid), 64'(1));
        check("hold_data", 64'({a_data, a_last}), 64'({hold_data, hold_last}));
      end
      if (a_mode) shifts++;
      if (a_head != '0) head_nz = 1'b1;
      if (a_done) dones++;
      a_ready   = ($urandom_range(99) < ready_pct);
      hold      = a_valid && !a_ready;
      hold_data = a_data;
      hold_last = a_last;
      if (a_valid && a_ready) begin
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("word", 64'({a_data, a_last}), 64'({w, exp_q.size() == 0}));
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected none", a_data);
        end
        words++;
      end
    end
    check("done_once", 64'(dones), 64'(1));
    check("word_count", 64'(words), 64'(3));
    check("shift_cycles", 64'(shifts), 64'(10));
    check("head_zero", 64'(head_nz), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_idle", 64'({a_busy, a_done, a_any}), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pre;
    logic [8:0] bw[$];
    bit         seen_shift;
    bit         restored;
    bit         b_done_seen;

    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_din = 8'hA5;
    c_start = 1'b0; c_ready = 1'b0; c_tail = 8'h5A;
    for (int i = 0; i < 10; i++) a_din[i] = 4'(i);
    build_vectors();
    tick();
    tick();
    check("reset_a", 64'({a_busy, a_done, a_any, a_mode, a_head, a_data, a_valid, a_last}), 64'(0));
    check("reset_b", 64'({b_busy, b_done, b_any, b_mode, b_head, b_data, b_valid, b_last}), 64'(0));
    check("reset_c", 64'({c_busy, c_done, c_any, c_mode, c_head, c_data, c_valid, c_last}), 64'(0));
    rst = 1'b0;

    apply_vecs();

    // START pulses mid-unload must not restart or add a DONE.
    run_unload(100, 1'b1);

    // Reset in cycle 4 of an unload.
    a_start = 1'b1;
    a_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      a_start = 1'b0;
    end
    rst = 1'b1;
    tick();
    check("rst_mid", 64'({a_busy, a_done, a_any, a_mode, a_head, a_data, a_valid, a_last}), 64'(0));
    rst = 1'b0;
    run_unload(100, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 10; k++) a_din[k] = 4'($urandom);
      run_unload($urandom_range(20, 90), 1'b0);
    end

    // Recirculating unload must leave the chain as it was.
    seen_shift = 1'b0;
    restored = 1'b0;
    b_done_seen = 1'b0;
    tick();
    pre = b_chain;
    b_start = 1'b1;
    for (int cyc = 1; cyc < 40 && !b_done_seen; cyc++) begin
      tick();
      b_start = 1'b0;
      if (seen_shift && !restored && !b_any) begin
        check("recirc_restore", 64'(b_chain), 64'(pre));
        restored = 1'b1;
      end
      if (b_mode) seen_shift = 1'b1;
      if (b_valid) bw.push_back({b_last, b_data});
      if (b_done) b_done_seen = 1'b1;
    end
    check("recirc_seen", 64'(restored), 64'(1));
    check("recirc_done", 64'(b_done_seen), 64'(1));
    check("recirc_nwords", 64'(bw.size()), 64'(2));
    if (bw.size() == 2) begin
      check("recirc_w0", 64'(bw[0]), 64'({1'b0, pre[7:0]}));
      check("recirc_w1", 64'(bw[1]), 64'({1'b1, 7'b0, pre[8]}));
    end

    // Single-slice chain with one blocked cycle before acceptance.
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("cc1_c1", 64'({c_any, c_mode, c_busy, c_valid}), 64'(4'b1110));
    tick();
    check("cc1_c2", 64'({c_any, c_mode, c_busy, c_valid, c_last, c_done}), 64'(6'b001110));
    check("cc1_c2_data", 64'(c_data), 64'(8'h5A));
    tick();
    check("cc1_c3", 64'({c_any, c_mode, c_busy, c_valid, c_last, c_done}), 64'(6'b001110));
    check("cc1_c3_data", 64'(c_data), 64'(8'h5A));
    c_ready = 1'b1;
    tick();
    check("cc1_c4", 64'({c_busy, c_valid, c_done}), 64'(3'b001));
    tick();
    check("cc1_c5", 64'({c_busy, c_valid, c_done}), 64'(3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_capture_ctrl.md
# scan_capture_ctrl

Capture-and-unload controller for a chain of scan sample registers. On request it freezes every register in the chain, shifts the chain out `SCAN_WIDTH` bits per cycle from the chain tail, and packs the slices into `WORD_WIDTH`-bit words on a valid/ready stream. It sits between the debug/readback host logic and the scan chain, and is the only driver of the chain's global scan controls.

## Interface
- `SCAN_WIDTH`, 1: bits per shift slice; equals the chain's scan lane width.
- `WORD_WIDTH`, 32: output word width; must be an integer multiple of `SCAN_WIDTH`.
- `CHAIN_CYCLES`, 64: shift cycles needed for one full unload. Equals the sum over all chain elements of (element width / `SCAN_WIDTH` + 1); the +1 is that element's scan stage.
- `RECIRC`, 0: 1 = chain head is fed from the chain tail during shift; 0 = chain head is fed with zeros.
- `CLK` in 1: sole clock; every register updates on posedge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: request an unload; sampled only in IDLE.
- `BUSY` out 1: high from the first shift cycle until the last word is accepted.
- `DONE` out 1: one-cycle pulse in the cycle after the last word is accepted.
- `SCAN_ANY` out 1: chain control; 0 = elements sample their data inputs, 1 = elements shift or hold.
- `SCAN_MODE` out 1: chain control; 1 with `SCAN_ANY` = shift, 0 with `SCAN_ANY` = hold.
- `CHAIN_HEAD` out `SCAN_WIDTH`: drives the first element's scan input.
- `CHAIN_TAIL` in `SCAN_WIDTH`: scan output of the last element.
- `WORD_DATA` out `WORD_WIDTH`: packed slices.
- `WORD_VALID` out 1: `WORD_DATA` is valid.
- `WORD_READY` in 1: consumer accepts; a transfer occurs on a cycle with `WORD_VALID && WORD_READY`.
- `WORD_LAST` out 1: marks the final word of an unload.

## Operation
- States: IDLE, SHIFT, STALL, DRAIN.
- IDLE:
  - Outputs: `SCAN_ANY`=0, `SCAN_MODE`=0, `BUSY`=0.
  - The chain samples freely.
  - `START`=1 -> SHIFT. Slice counter and accumulator are cleared.
- SHIFT:
  - Outputs: `SCAN_ANY`=1, `SCAN_MODE`=1.
  - Each edge registers `CHAIN_TAIL` as slice k, k = 0..`CHAIN_CYCLES`-1.
  - Slice k goes to word bits [(k mod P)*`SCAN_WIDTH` +: `SCAN_WIDTH`], where P = `WORD_WIDTH`/`SCAN_WIDTH`.
  - A slice that completes a word, or is slice `CHAIN_CYCLES`-1, loads the accumulator plus that slice directly into the output register at the same edge. The accumulator then clears.
- Final word: if `CHAIN_CYCLES` is not a multiple of P, its upper unused bits are 0 and `WORD_LAST`=1.
- Stall rule (decided registered): the next cycle is STALL (`SCAN_ANY`=1, `SCAN_MODE`=0, chain holds, no slice captured) if its slice would complete a word and the output register will still be occupied at the end of the current cycle.
- STALL -> SHIFT once the output register is free or being accepted.
- After slice `CHAIN_CYCLES`-1 -> DRAIN: `SCAN_ANY`=0 (chain resumes sampling), `BUSY`=1.
- DRAIN -> IDLE when the last word is accepted. `DONE`=1 in the following cycle.
- `CHAIN_HEAD`:
  - `RECIRC`=1: equals `CHAIN_TAIL` while `SCAN_MODE`=1.
  - Otherwise: 0.
- Stale scan-stage slices (one per element) are delivered unfiltered. The host strips them.
- `START` while not IDLE is ignored.
- Output word handshake:
  - `WORD_DATA` and `WORD_LAST` are stable while `WORD_VALID`=1 and `WORD_READY`=0.
  - `WORD_VALID` never deasserts without a transfer.
- `RST` in any state:
  - Next cycle is IDLE; all outputs 0; counters and accumulator cleared.
  - A partial unload is discarded and no `DONE` is issued.

## Timing
- Reset values: `BUSY`, `DONE`, `SCAN_ANY`, `SCAN_MODE`, `CHAIN_HEAD`, `WORD_DATA`, `WORD_VALID` and `WORD_LAST` are all 0.
- All outputs are registered except `CHAIN_HEAD` when `RECIRC`=1 (combinational from `CHAIN_TAIL`).
- `START`=1 in cycle 0 -> `SCAN_ANY`=`SCAN_MODE`=`BUSY`=1 from cycle 1. The chain's last capture is the edge ending cycle 0.
- Slice k is captured at the edge ending cycle k+1 (no stalls).
- A word completed at the edge ending cycle c has `WORD_VALID`=1 in cycle c+1.
- With `WORD_READY` held at 1 there are no stalls. Unload length: `CHAIN_CYCLES` shift cycles plus one cycle for the last word.
- Counter width: $clog2(`CHAIN_CYCLES`+1). It must not wrap past `CHAIN_CYCLES`-1.

## Test plan
- Parameters `SCAN_WIDTH`=4, `WORD_WIDTH`=16, `CHAIN_CYCLES`=10, `READY`=1, tail driven with slice index k.
  - `START` in cycle 0 -> `SCAN_MODE`=1 in cycles 1-10.
  - Words 0x3210 (cycle 5), 0x7654 (cycle 9), 0x0098 with `LAST` (cycle 11).
  - `DONE` in cycle 12.
- Same, `WORD_READY`=0 for cycles 5-14 -> `SCAN_MODE`=0 while a completing slice is blocked.
  - `WORD_DATA` held at 0x3210.
  - Total slices captured still 10; words unchanged.
- `RECIRC`=1 with a model chain of one 8-bit element, `SCAN_WIDTH`=1, `CHAIN_CYCLES`=9 -> after the unload the model chain register contents equal their pre-unload values.
- `START` pulsed in cycles 3 and 6 of an unload -> ignored; exactly one `DONE`.
- `RST` asserted in cycle 4 of an unload -> cycle 5 has all outputs 0.
  - A fresh `START` then yields the full 3-word sequence.
- `WORD_WIDTH`=`SCAN_WIDTH`=8, `CHAIN_CYCLES`=1 -> one word with `LAST`=1 in cycle 3; `DONE` one cycle after acceptance.
